// File: rtl/mem_wb_stage.sv
// Memory-to-writeback pipeline stage: muxes the writeback value at accept time and
// holds up to two results (head + skid) so a stalled register-file port never drops one.
module mem_wb_stage #(
    parameter int DATA_W = 128,
    parameter int REG_AW = 7,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mem_to_reg,
    input  logic              reg_write,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [REG_AW-1:0] reg_rt,
    input  logic              rf_ready,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  retired_count
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_in_ready;
    logic                r_head_we;
    logic [REG_AW-1:0]   r_head_addr;
    logic [DATA_W-1:0]   r_head_data;
    logic                r_skid_we;
    logic [REG_AW-1:0]   r_skid_addr;
    logic [DATA_W-1:0]   r_skid_data;
    logic [CNT_W-1:0]    r_retired;

    logic                w_accept;
    logic                w_retire;
    logic                w_load_head;
    logic                w_load_skid;
    logic                w_skid_to_head;
    logic [DATA_W-1:0]   w_in_data;

    assign w_in_data = mem_to_reg ? mem_read_data : alu_result;
    assign w_accept  = in_valid & r_in_ready;
    // Non-writing entries carry nothing for the register file, so they never wait on it.
    assign w_retire  = (r_state != S_EMPTY) & (rf_ready | ~r_head_we);

    always_comb begin
        w_state_nxt    = r_state;
        w_load_head    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_head = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = S_ONE;
                    w_load_head = 1'b1;
                end
            end
            S_ONE: begin
                if (w_accept && !w_retire) begin
                    w_state_nxt = S_TWO;
                    w_load_skid = 1'b1;
                end else if (w_retire && !w_accept) begin
                    w_state_nxt = S_EMPTY;
                end else if (w_accept && w_retire) begin
                    w_load_head = 1'b1;
                end
            end
            S_TWO: begin
                if (w_retire) begin
                    w_state_nxt    = S_ONE;
                    w_skid_to_head = 1'b1;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // in_ready is registered so it only rises on the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b0;
            r_retired  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != S_TWO);
            if (w_retire) r_retired <= r_retired + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head_we   <= 1'b0;
            r_head_addr <= '0;
            r_head_data <= '0;
            r_skid_we   <= 1'b0;
            r_skid_addr <= '0;
            r_skid_data <= '0;
        end else begin
            if (w_load_head) begin
                r_head_we   <= reg_write;
                r_head_addr <= reg_rt;
                r_head_data <= w_in_data;
            end else if (w_skid_to_head) begin
                r_head_we   <= r_skid_we;
                r_head_addr <= r_skid_addr;
                r_head_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_we   <= reg_write;
                r_skid_addr <= reg_rt;
                r_skid_data <= w_in_data;
            end
        end
    end

    assign in_ready      = r_in_ready;
    assign rf_we         = (r_state != S_EMPTY) & r_head_we;
    assign rf_addr       = r_head_addr;
    assign rf_wdata      = r_head_data;
    assign fwd_valid     = (r_state == S_TWO) ? r_skid_we   : ((r_state == S_ONE) & r_head_we);
    assign fwd_addr      = (r_state == S_TWO) ? r_skid_addr : r_head_addr;
    assign fwd_data      = (r_state == S_TWO) ? r_skid_data : r_head_data;
    assign retired_count = r_retired;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage; a second instance built with a 4-bit counter
// shares the stimulus to exercise retired_count wrap.
module tb_mem_wb_stage;

    localparam int DATA_W = 128;
    localparam int REG_AW = 7;

    localparam logic [DATA_W-1:0] MEM_A = {8{16'hAAAA}};
    localparam logic [DATA_W-1:0] ALU_5 = {8{16'h5555}};
    localparam logic [DATA_W-1:0] VAL_X = {4{32'hDEADBEEF}};
    localparam logic [DATA_W-1:0] VAL_Y = {4{32'h12345678}};
    localparam logic [DATA_W-1:0] VAL_Z = {4{32'hCAFEF00D}};

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              mem_to_reg;
    logic              reg_write;
    logic [DATA_W-1:0] mem_read_data;
    logic [DATA_W-1:0] alu_result;
    logic [REG_AW-1:0] reg_rt;
    logic              rf_ready;

    logic              in_ready;
    logic              rf_we;
    logic [REG_AW-1:0] rf_addr;
    logic [DATA_W-1:0] rf_wdata;
    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_addr;
    logic [DATA_W-1:0] fwd_data;
    logic [31:0]       retired_count;

    logic              in_ready_n;
    logic              rf_we_n;
    logic [REG_AW-1:0] rf_addr_n;
    logic [DATA_W-1:0] rf_wdata_n;
    logic              fwd_valid_n;
    logic [REG_AW-1:0] fwd_addr_n;
    logic [DATA_W-1:0] fwd_data_n;
    logic [3:0]        retired_count_n;

    int n_checks = 0;
    int n_errors = 0;

    mem_wb_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(32)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .mem_read_data(mem_read_data), .alu_result(alu_result), .reg_rt(reg_rt),
        .rf_ready(rf_ready), .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .retired_count(retired_count)
    );

    mem_wb_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(4)) u_dut_narrow (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_n),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .mem_read_data(mem_read_data), .alu_result(alu_result), .reg_rt(reg_rt),
        .rf_ready(rf_ready), .rf_we(rf_we_n), .rf_addr(rf_addr_n), .rf_wdata(rf_wdata_n),
        .fwd_valid(fwd_valid_n), .fwd_addr(fwd_addr_n), .fwd_data(fwd_data_n),
        .retired_count(retired_count_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic m2r,
                         input logic [REG_AW-1:0] rt,
                         input logic [DATA_W-1:0] mem, input logic [DATA_W-1:0] alu);
        in_valid      = v;
        reg_write     = we;
        mem_to_reg    = m2r;
        reg_rt        = rt;
        mem_read_data = mem;
        alu_result    = alu;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".in_ready"},  DATA_W'(in_ready),      '0);
        check({tag, ".rf_we"},     DATA_W'(rf_we),         '0);
        check({tag, ".rf_addr"},   DATA_W'(rf_addr),       '0);
        check({tag, ".rf_wdata"},  rf_wdata,               '0);
        check({tag, ".fwd_valid"}, DATA_W'(fwd_valid),     '0);
        check({tag, ".fwd_addr"},  DATA_W'(fwd_addr),      '0);
        check({tag, ".fwd_data"},  fwd_data,               '0);
        check({tag, ".count"},     DATA_W'(retired_count), '0);
        check({tag, ".count_n"},   DATA_W'(retired_count_n), '0);
    endtask

    initial begin
        reset    = 1'b0;
        rf_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        #12;
        check_all_zero("por");
        reset = 1'b1;
        step();
        check("rel.in_ready", DATA_W'(in_ready), 1);

        // back-to-back, rf_ready = 1, alternating mux select
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b1, (i % 2 == 1), REG_AW'(i), MEM_A, ALU_5);
            step();
            check("b2b.rf_we",    DATA_W'(rf_we),    1);
            check("b2b.rf_addr",  DATA_W'(rf_addr),  i);
            check("b2b.rf_wdata", rf_wdata, (i % 2 == 1) ? MEM_A : ALU_5);
            check("b2b.in_ready", DATA_W'(in_ready), 1);
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        step();
        check("b2b.idle_we", DATA_W'(rf_we), 0);
        check("b2b.count",   DATA_W'(retired_count), 4);

        // backpressure: A=reg5, B=reg6, C=reg7
        rf_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 7'd5, MEM_A, VAL_X);
        step();
        check("bp.a_in_ready", DATA_W'(in_ready), 1);
        check("bp.a_addr",     DATA_W'(rf_addr), 5);
        drive(1'b1, 1'b1, 1'b0, 7'd6, MEM_A, VAL_Y);
        step();
        check("bp.b_in_ready", DATA_W'(in_ready), 0);
        check("bp.b_addr",     DATA_W'(rf_addr), 5);
        drive(1'b1, 1'b1, 1'b0, 7'd7, MEM_A, VAL_Z);
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp.hold_in_ready", DATA_W'(in_ready), 0);
            check("bp.hold_addr",     DATA_W'(rf_addr), 5);
            check("bp.hold_data",     rf_wdata, VAL_X);
            check("bp.hold_we",       DATA_W'(rf_we), 1);
        end
        rf_ready = 1'b1;
        step();
        check("bp.out_b_addr", DATA_W'(rf_addr), 6);
        check("bp.out_b_data", rf_wdata, VAL_Y);
        check("bp.in_ready",   DATA_W'(in_ready), 1);
        step();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        check("bp.out_c_addr", DATA_W'(rf_addr), 7);
        check("bp.out_c_data", rf_wdata, VAL_Z);
        step();
        check("bp.idle_we", DATA_W'(rf_we), 0);
        check("bp.count",   DATA_W'(retired_count), 7);

        // non-writing entry ignores rf_ready
        rf_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 7'd9, MEM_A, ALU_5);
        step();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        check("nw.rf_we",     DATA_W'(rf_we), 0);
        check("nw.fwd_valid", DATA_W'(fwd_valid), 0);
        step();
        check("nw.rf_we2", DATA_W'(rf_we), 0);
        check("nw.count",  DATA_W'(retired_count), 8);

        // forwarding shows the newest entry
        drive(1'b1, 1'b1, 1'b1, 7'd10, VAL_X, ALU_5);
        step();
        check("fw.one_addr", DATA_W'(fwd_addr), 10);
        check("fw.one_data", fwd_data, VAL_X);
        drive(1'b1, 1'b1, 1'b0, 7'd20, MEM_A, VAL_Y);
        step();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        check("fw.two_valid", DATA_W'(fwd_valid), 1);
        check("fw.two_addr",  DATA_W'(fwd_addr), 20);
        check("fw.two_data",  fwd_data, VAL_Y);
        check("fw.two_rfadr", DATA_W'(rf_addr), 10);
        rf_ready = 1'b1;
        step();
        rf_ready = 1'b0;
        check("fw.ret_addr",  DATA_W'(fwd_addr), 20);
        check("fw.ret_data",  fwd_data, VAL_Y);
        check("fw.ret_rfadr", DATA_W'(rf_addr), 20);
        check("fw.ret_wdata", rf_wdata, VAL_Y);
        check("fw.count",     DATA_W'(retired_count), 9);

        // back into TWO, then async reset between edges
        drive(1'b1, 1'b1, 1'b0, 7'd30, MEM_A, VAL_Z);
        step();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        check("rst.pre_in_ready", DATA_W'(in_ready), 0);
        #2 reset = 1'b0;
        #1 check_all_zero("rst.async");
        #2 reset = 1'b1;
        rf_ready = 1'b1;
        step();
        check("rst.in_ready", DATA_W'(in_ready), 1);
        check("rst.rf_we",    DATA_W'(rf_we), 0);
        step();
        check("rst.rf_we2",   DATA_W'(rf_we), 0);
        check("rst.count",    DATA_W'(retired_count), 0);

        // 17 retires: narrow counter wraps to 1
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b1, 1'b0, REG_AW'(i + 40), MEM_A, ALU_5);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        step();
        check("wrap.count32", DATA_W'(retired_count), 17);
        check("wrap.count4",  DATA_W'(retired_count_n), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Pipeline stage between the SPU memory stage and the 128-entry register file write port. It captures the memory stage results (load data, ALU result, destination register) and selects the writeback value. It holds results in a two-entry skid buffer so a busy register-file port never drops a result. It also drives a forwarding bus and a retired-instruction counter.

## Interface
- DATA_W, 128, width of register/memory data
- REG_AW, 7, register address width (128 registers)
- CNT_W, 32, retired-instruction counter width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  memory stage presents a result this cycle
- in_ready  out  1  stage can accept; transfer when in_valid & in_ready
- mem_to_reg  in  1  1: write back mem_read_data; 0: write back alu_result
- reg_write  in  1  instruction writes a register
- mem_read_data  in  DATA_W  data memory read result
- alu_result  in  DATA_W  ALU result passed through memory stage
- reg_rt  in  REG_AW  destination register
- rf_ready  in  1  register file accepts a write this cycle
- rf_we  out  1  register file write enable
- rf_addr  out  REG_AW  write address
- rf_wdata  out  DATA_W  write data
- fwd_valid  out  1  forwarding bus holds a pending register write
- fwd_addr  out  REG_AW  forwarded destination
- fwd_data  out  DATA_W  forwarded value
- retired_count  out  CNT_W  instructions retired since reset

## Operation
- Entry = {we, addr, data}. At capture: we = reg_write, addr = reg_rt, data = mem_to_reg ? mem_read_data : alu_result. The mux is evaluated at accept time, not at retire.
- Storage: head entry plus skid entry. State machine is EMPTY / ONE / TWO.
- accept = in_valid & in_ready. retire = (state != EMPTY) & (rf_ready | ~head.we).
- Entries with we = 0 retire without waiting for rf_ready.
- EMPTY: accept -> ONE (incoming loads head).
- ONE:
  - accept & ~retire -> TWO (incoming loads skid).
  - retire & ~accept -> EMPTY.
  - accept & retire -> ONE (incoming loads head).
- TWO: in_ready = 0. retire -> ONE (skid moves to head). Otherwise hold.
- in_ready = reset & (state != TWO). It is a function of registered state only, with no combinational path from in_valid or rf_ready.
- rf_we = (state != EMPTY) & head.we. rf_addr and rf_wdata = head.addr and head.data.
- While rf_we = 1 and rf_ready = 0, rf_addr and rf_wdata hold stable.
- Forwarding shows the newest pending entry: skid in TWO, head in ONE. fwd_valid = newest.we. Register 0 is not special.
- retired_count increments by 1 on every retire, including we = 0 entries. It wraps from 2^CNT_W-1 to 0.
- Reset (async assert): state = EMPTY, both entries cleared.
  - All outputs 0: in_ready, rf_we, rf_addr, rf_wdata, fwd_valid, fwd_addr, fwd_data, retired_count.
  - Entries in flight are discarded.
  - in_ready rises on the first clock edge after deassertion, as a function of state EMPTY.

## Timing
- Latency: accept at edge N makes the entry visible on rf_* and fwd_* after edge N; the write is committed at edge N+1 if rf_ready = 1.
- Throughput: 1 entry per cycle while rf_ready = 1 (stays in ONE).
- rf_ready low for k cycles: at most one further accept, then in_ready = 0. No entry is lost or duplicated. Order is preserved.
- Accept and retire in the same cycle are always legal in ONE. Only retire is legal in TWO.
- retired_count updates on the same edge as the retire.

## Test plan
- Back-to-back flow, rf_ready = 1:
  - Stimulus: 4 writes with reg_rt = 1..4, alternating mem_to_reg = 1 (mem_read_data = 0xAAAA…) and mem_to_reg = 0 (alu_result = 0x5555…).
  - Required: rf_we pulses at cycles 1..4 with the matching addr/data; in_ready stays 1; retired_count = 4.
- Backpressure:
  - Stimulus: rf_ready = 0 for 5 cycles while in_valid = 1 with entries A, B, C.
  - Required: A and B accepted, in_ready = 0 from the cycle after B. rf_addr = A.addr is stable for all 5 cycles. After rf_ready rises, writes come out A, B, C in order.
- Non-writing entries:
  - Stimulus: reg_write = 0 entry with rf_ready = 0.
  - Required: it retires the next cycle, rf_we stays 0, retired_count increments.
- Forwarding in TWO:
  - Stimulus: head reg 10 = X and skid reg 20 = Y, with rf_ready held 0.
  - Required: fwd_addr = 20, fwd_data = Y, fwd_valid = 1. After one retire, fwd_addr stays 20 with head = Y.
- Reset mid-operation:
  - Stimulus: assert reset low asynchronously between edges while in state TWO.
  - Required: all outputs 0 immediately with no clock edge; after deassertion in_ready = 1 and no stale write appears on rf_we.
- Counter wrap:
  - Stimulus: CNT_W = 4 build, 17 retires.
  - Required: retired_count = 1.
